// File: rtl/layer_mvm_par.sv
// Fully-connected layer y = act(W*x + b) with P parallel MAC lanes; W and b come from external synchronous ROMs.
// Define LAYER_MVM_RELU_EN to add a ReLU after saturation; left undefined, the layer is linear.
module layer_mvm_par #(
  parameter int N = 8,
  parameter int M = 6,
  parameter int P = 1,
  parameter int T = 16,
  localparam int G    = M / P,
  localparam int WA_W = (G * N > 1) ? $clog2(G * N) : 1,
  localparam int BA_W = (G > 1) ? $clog2(G) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [T-1:0]      data_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [T-1:0]      data_out,
  output logic [WA_W-1:0]   w_addr,
  input  logic [P*T-1:0]    w_data,
  output logic [BA_W-1:0]   b_addr,
  input  logic [P*T-1:0]    b_data
);

  localparam int ACC_W = 2 * T + $clog2(N) + 1;
  localparam int XW    = $clog2(N);
  localparam int YW    = (M > 1) ? $clog2(M) : 1;
  localparam int CW    = $clog2(N + 2);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - T + 1){1'b0}}, {(T - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - T + 1){1'b1}}, {(T - 1){1'b0}}};

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t                  state;
  logic [XW-1:0]           idx;
  logic [XW-1:0]           xk;
  logic [YW-1:0]           j;
  logic [YW-1:0]           y_base;
  logic [CW-1:0]           cyc;
  logic [BA_W-1:0]         grp;
  logic [WA_W-1:0]         w_base;
  logic signed [T-1:0]     x_buf [N];
  logic signed [T-1:0]     y_buf [M];
  logic signed [ACC_W-1:0] acc [P];
  logic signed [ACC_W-1:0] acc_next [P];
  logic signed [2*T-1:0]   prod [P];
  logic signed [T-1:0]     res [P];
  logic signed [T-1:0]     x_cur;

  // s_ready is gated by reset so it is low for the whole time reset is held
  assign s_ready  = (state == LOAD) && !reset;
  assign m_valid  = (state == OUTPUT);
  assign data_out = m_valid ? y_buf[j] : '0;

  always_comb begin
    x_cur = x_buf[xk];
    for (int p = 0; p < P; p++) begin
      prod[p] = $signed({{T{w_data[p*T+T-1]}}, w_data[p*T +: T]}) *
                $signed({{T{x_cur[T-1]}}, x_cur});
      // the first accumulating cycle of a group starts from the bias instead of the old sum
      acc_next[p] = ((cyc == CW'(1)) ? {{(ACC_W - T){b_data[p*T+T-1]}}, b_data[p*T +: T]} : acc[p])
                    + {{(ACC_W - 2*T){prod[p][2*T-1]}}, prod[p]};
      if (acc[p] > SAT_MAX) begin
        res[p] = SAT_MAX[T-1:0];
      end else if (acc[p] < SAT_MIN) begin
        res[p] = SAT_MIN[T-1:0];
      end else begin
        res[p] = acc[p][T-1:0];
      end
`ifdef LAYER_MVM_RELU_EN
      if (res[p][T-1]) begin
        res[p] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= LOAD;
      idx    <= '0;
      xk     <= '0;
      j      <= '0;
      y_base <= '0;
      cyc    <= '0;
      grp    <= '0;
      w_base <= '0;
      w_addr <= '0;
      b_addr <= '0;
      for (int i = 0; i < N; i++) x_buf[i] <= '0;
      for (int i = 0; i < M; i++) y_buf[i] <= '0;
      for (int p = 0; p < P; p++) acc[p] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (s_valid) begin
            x_buf[idx] <= data_in;
            if (idx == XW'(N - 1)) begin
              idx    <= '0;
              xk     <= '0;
              cyc    <= '0;
              grp    <= '0;
              w_base <= '0;
              y_base <= '0;
              w_addr <= '0;
              b_addr <= '0;
              state  <= COMPUTE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        // each group: address cycle, N accumulate cycles, one write-back cycle
        COMPUTE: begin
          if (cyc != '0 && cyc <= CW'(N)) begin
            for (int p = 0; p < P; p++) acc[p] <= acc_next[p];
            if (xk != XW'(N - 1)) xk <= xk + 1'b1;
          end
          if (cyc < CW'(N - 1)) begin
            w_addr <= w_addr + 1'b1;
          end
          if (cyc == CW'(N + 1)) begin
            for (int p = 0; p < P; p++) y_buf[y_base + YW'(p)] <= res[p];
            cyc <= '0;
            xk  <= '0;
            if (grp == BA_W'(G - 1)) begin
              grp    <= '0;
              w_base <= '0;
              y_base <= '0;
              w_addr <= '0;
              b_addr <= '0;
              j      <= '0;
              state  <= OUTPUT;
            end else begin
              grp    <= grp + 1'b1;
              b_addr <= grp + 1'b1;
              w_base <= w_base + WA_W'(N);
              w_addr <= w_base + WA_W'(N);
              y_base <= y_base + YW'(P);
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end

        OUTPUT: begin
          if (m_ready) begin
            if (j == YW'(M - 1)) begin
              j     <= '0;
              state <= LOAD;
            end else begin
              j <= j + 1'b1;
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_mvm_par.sv
// Self-checking bench for layer_mvm_par (N=4, M=4, P=2, T=16) with behavioural weight/bias ROMs and an arithmetic reference model.
// Honours LAYER_MVM_RELU_EN the same way the design does.
module tb_layer_mvm_par;

  localparam int NN  = 4;
  localparam int MM  = 4;
  localparam int PP  = 2;
  localparam int TT  = 16;
  localparam int GG  = MM / PP;
  localparam int WAW = $clog2(GG * NN);
  localparam int BAW = (GG > 1) ? $clog2(GG) : 1;
`ifdef LAYER_MVM_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           s_valid;
  logic           s_ready;
  logic [TT-1:0]  data_in;
  logic           m_valid;
  logic           m_ready = 1'b1;
  logic [TT-1:0]  data_out;
  logic [WAW-1:0] w_addr;
  logic [PP*TT-1:0] w_data;
  logic [BAW-1:0] b_addr;
  logic [PP*TT-1:0] b_data;

  logic signed [TT-1:0] wmem [MM][NN];
  logic signed [TT-1:0] bmem [MM];
  logic signed [TT-1:0] xv [NN];
  int exp_q [$];
  int n_checks = 0;
  int n_pass = 0;
  int mr_mode = 0;
  int out_cnt = 0;
  bit ready_due = 1'b0;
  int cnt;

  layer_mvm_par #(.N(NN), .M(MM), .P(PP), .T(TT)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .b_addr   (b_addr),
    .b_data   (b_data)
  );

  always #5 clk = ~clk;

  // synchronous ROMs: one cycle from address to data
  always @(posedge clk) begin
    for (int p = 0; p < PP; p++) begin
      w_data[p*TT +: TT] <= wmem[(int'(w_addr) / NN) * PP + p][int'(w_addr) % NN];
      b_data[p*TT +: TT] <= bmem[int'(b_addr) * PP + p];
    end
  end

  // downstream readiness: 0 = always ready, 1 = random, 2 = stalled
  always @(posedge clk) begin
    #1;
    case (mr_mode)
      1:       m_ready = 1'($urandom_range(1));
      2:       m_ready = 1'b0;
      default: m_ready = 1'b1;
    endcase
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  function automatic int model_y(input int i);
    longint a;
    a = bmem[i];
    for (int k = 0; k < NN; k++) a += longint'(wmem[i][k]) * longint'(xv[k]);
    if (a > 32767) a = 32767;
    else if (a < -32768) a = -32768;
    if (RELU && a < 0) a = 0;
    return int'(a);
  endfunction

  task automatic push_expected();
    for (int i = 0; i < MM; i++) exp_q.push_back(model_y(i));
  endtask

  task automatic send_vec(input int max_gap);
    int n;
    for (int i = 0; i < NN; i++) begin
      repeat ($urandom_range(max_gap)) begin
        s_valid = 1'b0;
        data_in = 16'($urandom);
        @(negedge clk);
      end
      s_valid = 1'b1;
      data_in = xv[i];
      n = 0;
      while (!s_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (!s_ready) check("s_ready_timeout", 0, 1);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_outputs", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_weights();
    for (int i = 0; i < MM; i++) begin
      bmem[i] = 16'($urandom);
      for (int k = 0; k < NN; k++) wmem[i][k] = 16'($urandom);
    end
  endtask

  task automatic rand_x();
    for (int k = 0; k < NN; k++) xv[k] = 16'($urandom);
  endtask

  // compare process: every valid output against the model queue, plus s_ready right after each vector
  always @(negedge clk) begin
    if (reset) begin
      out_cnt   = 0;
      ready_due = 1'b0;
    end else begin
      if (ready_due) begin
        check("s_ready_after_last", int'(s_ready && !m_valid), 1);
        ready_due = 1'b0;
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          check("data_out", int'($signed(data_out)), exp_q[0]);
          if (m_ready) begin
            void'(exp_q.pop_front());
            out_cnt++;
            if (out_cnt % MM == 0) ready_due = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    data_in = '0;
    for (int i = 0; i < MM; i++) begin
      bmem[i] = '0;
      for (int k = 0; k < NN; k++) wmem[i][k] = (i == k) ? 16'sd1 : 16'sd0;
    end
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_b_addr", b_addr, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check("release_s_ready", s_ready, 1);
    @(negedge clk);

    // identity, latency and backpressure
    for (int k = 0; k < NN; k++) xv[k] = 16'(k + 1);
    for (int i = 0; i < MM; i++) check("model_identity", model_y(i), i + 1);
    push_expected();
    send_vec(0);
    check("s_ready_drop", s_ready, 0);
    cnt = 0;
    while (!m_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("first_valid_latency", cnt, 12);
    mr_mode = 2;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", m_valid, 1);
      check("stall_data", int'($signed(data_out)), 2);
      if (c == 4) mr_mode = 0;
      @(negedge clk);
    end
    drain();

    // bias and sign
    for (int i = 0; i < MM; i++)
      for (int k = 0; k < NN; k++) wmem[i][k] = 16'sd1;
    bmem[0] = -16'sd20;
    bmem[1] = 16'sd5;
    bmem[2] = 16'sd0;
    bmem[3] = -16'sd1;
    for (int k = 0; k < NN; k++) xv[k] = 16'sd2;
    check("model_bias0", model_y(0), RELU ? 0 : -12);
    check("model_bias1", model_y(1), 13);
    check("model_bias2", model_y(2), 8);
    check("model_bias3", model_y(3), 7);
    push_expected();
    send_vec(3);
    drain();

    // positive and negative saturation
    for (int i = 0; i < MM; i++) begin
      bmem[i] = '0;
      for (int k = 0; k < NN; k++) wmem[i][k] = 16'sd32767;
    end
    for (int k = 0; k < NN; k++) xv[k] = 16'sd32767;
    check("model_sat_pos", model_y(0), 32767);
    push_expected();
    send_vec(0);
    drain();
    for (int i = 0; i < MM; i++)
      for (int k = 0; k < NN; k++) wmem[i][k] = -16'sd32767;
    check("model_sat_neg", model_y(0), RELU ? 0 : -32768);
    push_expected();
    send_vec(0);
    drain();

    // asynchronous reset during group 1 of COMPUTE
    rand_weights();
    rand_x();
    send_vec(0);
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_s_ready", s_ready, 0);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_data_out", data_out, 0);
    exp_q.delete();
    #20 reset = 1'b0;
    #1 check("midrst_release_s_ready", s_ready, 1);
    @(negedge clk);
    rand_x();
    push_expected();
    send_vec(2);
    drain();

    // back-to-back vectors with m_ready held high
    rand_weights();
    for (int v = 0; v < 3; v++) begin
      rand_x();
      push_expected();
      send_vec(0);
    end
    drain();

    // random data, random input gaps and random backpressure
    mr_mode = 1;
    for (int b = 0; b < 2; b++) begin
      rand_weights();
      for (int v = 0; v < 3; v++) begin
        rand_x();
        push_expected();
        send_vec(3);
      end
      drain();
    end
    mr_mode = 0;
    repeat (3) @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
